// File: rtl/arbiter_2way.sv
// arbiter_2way: two-requester grant arbiter for one shared resource.
// Grants are registered and one-hot-or-zero. A grant is held while its owner
// keeps requesting. Ties from idle go to req_0, or alternate when RR_TIE = 1.
// MAX_HOLD > 0 bounds how long a holder can keep the grant while the other
// requester waits.
module arbiter_2way #(
    parameter int RR_TIE   = 0,
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Last hold-counter value before a forced hand-off. Zero when MAX_HOLD = 0,
    // where it is never used.
    localparam int              HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST  = HOLD_LAST_I[CNT_W-1:0];
    localparam bit              HOLD_EN     = (MAX_HOLD != 0);
    localparam bit              RR_EN       = (RR_TIE != 0);

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_idle_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;
    logic             r_last_grant;
    logic             w_last_grant_next;
    logic             w_other_req;
    logic             w_hold_expired;
    logic             w_tie_to_1;

    // Tie winner from idle: requester 1 only when round-robin is enabled and 0 was granted last.
    always_comb begin
        w_tie_to_1 = RR_EN && !r_last_grant;
    end

    // Destination chosen from idle. Also reused when the owner releases the grant.
    always_comb begin
        w_idle_next = IDLE;
        if (req_0 && req_1) begin
            w_idle_next = w_tie_to_1 ? GNT1 : GNT0;
        end else if (req_0) begin
            w_idle_next = GNT0;
        end else if (req_1) begin
            w_idle_next = GNT1;
        end
    end

    // Hold-limit detection: the owner has used its budget and the other side is waiting.
    always_comb begin
        w_other_req = 1'b0;
        case (r_state)
            GNT0:    w_other_req = req_1;
            GNT1:    w_other_req = req_0;
            default: w_other_req = 1'b0;
        endcase
        w_hold_expired = HOLD_EN && w_other_req && (r_hold_cnt == HOLD_LAST);
    end

    // Next-state logic. A release re-arbitrates in the same edge, so hand-off has no idle gap.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: w_next_state = w_idle_next;
            GNT0: begin
                if (!req_0) begin
                    w_next_state = w_idle_next;
                end else if (w_hold_expired) begin
                    w_next_state = GNT1;
                end else begin
                    w_next_state = GNT0;
                end
            end
            GNT1: begin
                if (!req_1) begin
                    w_next_state = w_idle_next;
                end else if (w_hold_expired) begin
                    w_next_state = GNT0;
                end else begin
                    w_next_state = GNT1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Hold counter counts cycles the owner keeps the grant under contention, saturating at HOLD_LAST.
    always_comb begin
        w_hold_cnt_next = r_hold_cnt;
        if (!HOLD_EN || !w_other_req || (w_next_state != r_state)) begin
            w_hold_cnt_next = '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
            w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
        end
    end

    // Remember who was granted most recently. This is updated only on entry to a grant state.
    always_comb begin
        w_last_grant_next = r_last_grant;
        if (w_next_state == GNT0 && r_state != GNT0) begin
            w_last_grant_next = 1'b0;
        end else if (w_next_state == GNT1 && r_state != GNT1) begin
            w_last_grant_next = 1'b1;
        end
    end

    // State, counter and history registers. Reset drops any grant in progress.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_hold_cnt   <= w_hold_cnt_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Grants decode from registered state only, so there is no request-to-grant combinational path.
    always_comb begin
        gnt_0 = (r_state == GNT0);
        gnt_1 = (r_state == GNT1);
    end

endmodule

// File: tb/tb_arbiter_2way.sv
// tb_arbiter_2way: directed scoreboard bench for three arbiter configurations
// (fixed priority, round-robin tie-break, and MAX_HOLD = 4).
module tb_arbiter_2way;

    logic       clock;
    logic       rst_n;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] g0;
    logic [2:0] g1;

    int checks;
    int errors;

    typedef struct {
        int         dut;
        logic [1:0] exp;   // {gnt_0, gnt_1} after the edge
    } exp_t;

    exp_t q[$];

    arbiter_2way #(.RR_TIE(0), .MAX_HOLD(0), .CNT_W(8)) u_fp (
        .clock(clock), .reset(rst_n), .req_0(r0[0]), .req_1(r1[0]),
        .gnt_0(g0[0]), .gnt_1(g1[0]));

    arbiter_2way #(.RR_TIE(1), .MAX_HOLD(0), .CNT_W(8)) u_rr (
        .clock(clock), .reset(rst_n), .req_0(r0[1]), .req_1(r1[1]),
        .gnt_0(g0[1]), .gnt_1(g1[1]));

    arbiter_2way #(.RR_TIE(0), .MAX_HOLD(4), .CNT_W(8)) u_mh (
        .clock(clock), .reset(rst_n), .req_0(r0[2]), .req_1(r1[2]),
        .gnt_0(g0[2]), .gnt_1(g1[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus to DUT d, and queue the grants expected after the next edge.
    task automatic step(input int d, input logic rst, input logic a, input logic b,
                        input logic e0, input logic e1);
        exp_t item;
        rst_n = rst;
        r0 = '0;
        r1 = '0;
        r0[d] = a;
        r1[d] = b;
        item.dut = d;
        item.exp = {e0, e1};
        q.push_back(item);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Monitor: after every edge, pop one expectation and check that no DUT grants both clients.
    initial begin
        exp_t it;
        logic [1:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                act = {g0[it.dut], g1[it.dut]};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL grant dut%0d t=%0t: got gnt_0/gnt_1=%b, expected %b",
                             it.dut, $time, act, it.exp);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ((g0[k] & g1[k]) !== 1'b0) begin
                    errors++;
                    $display("FAIL mutex dut%0d t=%0t: got gnt_0=%b gnt_1=%b, expected not both",
                             k, $time, g0[k], g1[k]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        r0     = '0;
        r1     = '0;

        // Fixed priority: reset with both requests high, then release.
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // Single requests give a one-cycle grant, delayed by one edge.
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        // Simultaneous requests, then a direct hand-off with no idle cycle.
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0, 1);
        // Without a hold limit, req_0 does not preempt the holder.
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // Reset drops a grant in progress.
        step(0, 1, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // Round-robin: the first tie after reset goes to 0, then ties alternate.
        step(1, 1, 1, 1, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        // A single grant to 0 updates the history, so the next tie goes to 1.
        step(1, 1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0);

        // Hold limit 4: both high gives four cycles to each side, alternating.
        for (int i = 0; i < 4; i++) step(2, 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(2, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(2, 1, 1, 1, 1, 0);
        // The waiting side drops, which clears the counter, so the owner gets a fresh budget.
        step(2, 1, 1, 0, 1, 0);
        step(2, 1, 1, 1, 1, 0);
        step(2, 1, 1, 1, 1, 0);
        step(2, 1, 1, 1, 1, 0);
        step(2, 1, 1, 1, 0, 1);
        // Without contention, a holder is never forced off.
        step(2, 1, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(2, 1, 0, 1, 0, 1);
        step(2, 1, 0, 0, 0, 0);

        @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
